// File: rtl/imap_pp_buf.sv
// imap_pp_buf: ping-pong input feature map buffer between the imap BIU and
// the MAC array. The BIU fills one page while the array reads RD_LANES
// strided words per request from the other page. Lanes that land in the
// same bank are serialised over extra ISSUE cycles.
//
// Optional build macro IMAP_PP_BUF_STAT_EN: adds the stall_cnt port, a
// saturating count of extra ISSUE cycles caused by bank conflicts.
module imap_pp_buf #(
    parameter int DATA_W      = 64,
    parameter int NUM_BANKS   = 8,
    parameter int BANK_AW     = 12,
    parameter int RD_LANES    = 4,
    parameter int LANE_STRIDE = 6272,
    parameter int ADDR_W      = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         wr_last,
    input  logic                         rd_req_valid,
    output logic                         rd_req_ready,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic                         rd_rsp_valid,
    output logic [RD_LANES*DATA_W-1:0]   rd_data,
    input  logic                         rd_release,
    output logic [1:0]                   page_full
`ifdef IMAP_PP_BUF_STAT_EN
    ,
    output logic [31:0]                  stall_cnt
`endif
);

    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int DEC_W  = BANK_AW + BANK_W;
    localparam int DEPTH  = 1 << BANK_AW;

    typedef enum logic [1:0] {PG_EMPTY, PG_FILLING, PG_FULL} page_st_t;
    typedef enum logic [1:0] {RD_IDLE, RD_ISSUE, RD_DONE} rd_st_t;

    // Storage: two pages of NUM_BANKS banks each
    logic [DATA_W-1:0] mem [2][NUM_BANKS][DEPTH];

    page_st_t          page_st [2];
    logic              wr_page;
    logic              rd_page;
    logic              rel_pend;
    rd_st_t            rd_st;
    logic [RD_LANES-1:0] pend;
    logic [BANK_W-1:0] lane_bank [RD_LANES];
    logic [BANK_AW-1:0] lane_off [RD_LANES];
    logic [DATA_W-1:0] hold [RD_LANES];

    logic [ADDR_W-1:0] lane_addr [RD_LANES];
    logic [RD_LANES-1:0] serve;
    logic [BANK_AW-1:0] bank_off [NUM_BANKS];
    logic [DATA_W-1:0] bank_rdata [NUM_BANKS];

    logic              wr_fire;
    logic              rd_accept;
    logic              rd_full;
    logic              rel_req;
    logic              rel_now;
    logic [BANK_W-1:0] wr_bank;
    logic [BANK_AW-1:0] wr_off;
    logic              unused_bits;

    assign wr_ready     = (page_st[wr_page] != PG_FULL);
    assign rd_full      = (page_st[rd_page] == PG_FULL);
    assign rd_req_ready = rd_full && (rd_st == RD_IDLE);
    assign page_full    = {page_st[1] == PG_FULL, page_st[0] == PG_FULL};
    assign wr_fire      = wr_valid && wr_ready;
    assign rd_accept    = rd_req_valid && rd_req_ready;
    assign wr_bank      = wr_addr[BANK_AW +: BANK_W];
    assign wr_off       = wr_addr[BANK_AW-1:0];

    // A release is held back while a read on the page is in flight and is
    // applied on the edge that leaves DONE, so the page never empties under
    // an active read and no new request can slip in on the stale page.
    assign rel_req = rd_release || rel_pend;
    assign rel_now = rel_req && rd_full &&
                     (((rd_st == RD_IDLE) && !rd_accept) || (rd_st == RD_DONE));

    // Lane addresses: base plus a multiple of the stride, wrapping in ADDR_W bits
    always_comb begin
        for (int j = 0; j < RD_LANES; j++) begin
            lane_addr[j] = rd_addr + ADDR_W'(j) * ADDR_W'(LANE_STRIDE);
        end
    end

    // Address bits above the page size are deliberately ignored
    always_comb begin
        unused_bits = ^wr_addr[ADDR_W-1:DEC_W];
        for (int j = 0; j < RD_LANES; j++) begin
            unused_bits = unused_bits ^ (^lane_addr[j][ADDR_W-1:DEC_W]);
        end
    end

    // Conflict arbitration: a pending lane is served unless a lower pending lane wants the same bank
    always_comb begin
        serve = '0;
        for (int j = 0; j < RD_LANES; j++) begin
            serve[j] = pend[j];
            for (int k = 0; k < j; k++) begin
                if (pend[k] && (lane_bank[k] == lane_bank[j])) begin
                    serve[j] = 1'b0;
                end
            end
        end
    end

    // Per-bank read port: each bank of the read page sees at most one address per cycle
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_off[b] = '0;
            for (int j = 0; j < RD_LANES; j++) begin
                if (serve[j] && (lane_bank[j] == BANK_W'(b))) begin
                    bank_off[b] = lane_off[j];
                end
            end
            bank_rdata[b] = mem[rd_page][b][bank_off[b]];
        end
    end

    // Write port into the page currently being filled (no reset on storage)
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_page][wr_bank][wr_off] <= wr_data;
        end
    end

    // Page bookkeeping: fill/full/release state and the two page pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            page_st[0] <= PG_EMPTY;
            page_st[1] <= PG_EMPTY;
            wr_page    <= 1'b0;
            rd_page    <= 1'b0;
            rel_pend   <= 1'b0;
        end else begin
            if (wr_fire) begin
                if (wr_last) begin
                    page_st[wr_page] <= PG_FULL;
                end else if (page_st[wr_page] == PG_EMPTY) begin
                    page_st[wr_page] <= PG_FILLING;
                end
            end
            if (rel_now) begin
                page_st[rd_page] <= PG_EMPTY;
            end
            wr_page  <= wr_page ^ (wr_fire && wr_last);
            rd_page  <= rd_page ^ rel_now;
            rel_pend <= rel_req && rd_full && !rel_now;
        end
    end

    // Read FSM: latch lanes on accept, issue conflict-free groups, pulse the response
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_st        <= RD_IDLE;
            pend         <= '0;
            rd_rsp_valid <= 1'b0;
            for (int j = 0; j < RD_LANES; j++) begin
                lane_bank[j] <= '0;
                lane_off[j]  <= '0;
                hold[j]      <= '0;
            end
        end else begin
            case (rd_st)
                RD_IDLE: begin
                    rd_rsp_valid <= 1'b0;
                    if (rd_accept) begin
                        for (int j = 0; j < RD_LANES; j++) begin
                            lane_bank[j] <= lane_addr[j][BANK_AW +: BANK_W];
                            lane_off[j]  <= lane_addr[j][BANK_AW-1:0];
                        end
                        pend  <= '1;
                        rd_st <= RD_ISSUE;
                    end
                end
                RD_ISSUE: begin
                    for (int j = 0; j < RD_LANES; j++) begin
                        if (serve[j]) begin
                            hold[j] <= bank_rdata[lane_bank[j]];
                        end
                    end
                    pend <= pend & ~serve;
                    if ((pend & ~serve) == '0) begin
                        rd_st        <= RD_DONE;
                        rd_rsp_valid <= 1'b1;
                    end
                end
                RD_DONE: begin
                    rd_rsp_valid <= 1'b0;
                    rd_st        <= RD_IDLE;
                end
                default: begin
                    rd_rsp_valid <= 1'b0;
                    rd_st        <= RD_IDLE;
                end
            endcase
        end
    end

    // Response data is the lane-indexed hold register
    always_comb begin
        for (int j = 0; j < RD_LANES; j++) begin
            rd_data[j*DATA_W +: DATA_W] = hold[j];
        end
    end

`ifdef IMAP_PP_BUF_STAT_EN
    // Count ISSUE cycles beyond the first of each request, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if ((rd_st == RD_ISSUE) && (pend != '1) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imap_pp_buf.sv
// tb_imap_pp_buf: directed bench for imap_pp_buf. Three instances share all
// inputs and differ only in LANE_STRIDE (6272, 4096, 1), so a single page
// fill serves the conflict-free, distinct-bank and all-same-bank cases.
// stall_cnt is checked only when IMAP_PP_BUF_STAT_EN is defined.
module tb_imap_pp_buf;

    typedef struct {
        logic [31:0]  addr;
        logic [255:0] exp_a;
        logic [255:0] exp_b;
        logic [255:0] exp_c;
        int           lat_a;
        int           lat_b;
        int           lat_c;
    } rd_vec_t;

    logic         clk;
    logic         rst;
    logic         wr_valid;
    logic [31:0]  wr_addr;
    logic [63:0]  wr_data;
    logic         wr_last;
    logic         rd_req_valid;
    logic [31:0]  rd_addr;
    logic         rd_release;

    logic         wr_ready_a, wr_ready_b, wr_ready_c;
    logic         rd_req_ready_a, rd_req_ready_b, rd_req_ready_c;
    logic         rd_rsp_valid_a, rd_rsp_valid_b, rd_rsp_valid_c;
    logic [255:0] rd_data_a, rd_data_b, rd_data_c;
    logic [1:0]   page_full_a, page_full_b, page_full_c;
`ifdef IMAP_PP_BUF_STAT_EN
    logic [31:0]  stall_cnt_a, stall_cnt_b, stall_cnt_c;
    int           exp_stall_c;
`endif

    int checks;
    int failures;
    rd_vec_t vecs [4];

    imap_pp_buf #(.LANE_STRIDE(6272)) dut_a (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready_a), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_last(wr_last),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready_a),
        .rd_addr(rd_addr), .rd_rsp_valid(rd_rsp_valid_a), .rd_data(rd_data_a),
        .rd_release(rd_release), .page_full(page_full_a)
`ifdef IMAP_PP_BUF_STAT_EN
        , .stall_cnt(stall_cnt_a)
`endif
    );

    imap_pp_buf #(.LANE_STRIDE(4096)) dut_b (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready_b), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_last(wr_last),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready_b),
        .rd_addr(rd_addr), .rd_rsp_valid(rd_rsp_valid_b), .rd_data(rd_data_b),
        .rd_release(rd_release), .page_full(page_full_b)
`ifdef IMAP_PP_BUF_STAT_EN
        , .stall_cnt(stall_cnt_b)
`endif
    );

    imap_pp_buf #(.LANE_STRIDE(1)) dut_c (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready_c), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_last(wr_last),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready_c),
        .rd_addr(rd_addr), .rd_rsp_valid(rd_rsp_valid_c), .rd_data(rd_data_c),
        .rd_release(rd_release), .page_full(page_full_c)
`ifdef IMAP_PP_BUF_STAT_EN
        , .stall_cnt(stall_cnt_c)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] mk4(input logic [63:0] l0, input logic [63:0] l1,
                                         input logic [63:0] l2, input logic [63:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] actual,
                               input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_rsp_valid"},
                    256'({rd_rsp_valid_c, rd_rsp_valid_b, rd_rsp_valid_a}), 256'(3'b000));
        checkOutput({tag, "_page_full"},
                    256'({page_full_c, page_full_b, page_full_a}), 256'(6'b000000));
        checkOutput({tag, "_req_ready"},
                    256'({rd_req_ready_c, rd_req_ready_b, rd_req_ready_a}), 256'(3'b000));
        checkOutput({tag, "_wr_ready"},
                    256'({wr_ready_c, wr_ready_b, wr_ready_a}), 256'(3'b111));
        checkOutput({tag, "_rd_data_a"}, rd_data_a, 256'd0);
        checkOutput({tag, "_rd_data_c"}, rd_data_c, 256'd0);
`ifdef IMAP_PP_BUF_STAT_EN
        checkOutput({tag, "_stall_cnt"},
                    256'({stall_cnt_c, stall_cnt_b, stall_cnt_a}), 256'd0);
`endif
    endtask

    // Request one read on all instances and time each response
    task automatic applyStimulus(input rd_vec_t v, input string tag);
        int cycle;
        logic got_a, got_b, got_c;
        logic busy_a, busy_b, busy_c;
        int lat_a, lat_b, lat_c;
        logic [255:0] dat_a, dat_b, dat_c;
        got_a = 1'b0; got_b = 1'b0; got_c = 1'b0;
        busy_a = 1'b0; busy_b = 1'b0; busy_c = 1'b0;
        lat_a = 0; lat_b = 0; lat_c = 0;
        dat_a = '0; dat_b = '0; dat_c = '0;
        @(negedge clk);
        checkOutput({tag, "_req_ready"},
                    256'({rd_req_ready_c, rd_req_ready_b, rd_req_ready_a}), 256'(3'b111));
        rd_addr = v.addr;
        rd_req_valid = 1'b1;
        @(negedge clk);
        rd_req_valid = 1'b0;
        cycle = 1;
        while (!(got_a && got_b && got_c) && cycle < 16) begin
            if (!got_a && rd_rsp_valid_a) begin got_a = 1'b1; lat_a = cycle; dat_a = rd_data_a; end
            else if (!got_a && rd_req_ready_a) busy_a = 1'b1;
            if (!got_b && rd_rsp_valid_b) begin got_b = 1'b1; lat_b = cycle; dat_b = rd_data_b; end
            else if (!got_b && rd_req_ready_b) busy_b = 1'b1;
            if (!got_c && rd_rsp_valid_c) begin got_c = 1'b1; lat_c = cycle; dat_c = rd_data_c; end
            else if (!got_c && rd_req_ready_c) busy_c = 1'b1;
            if (!(got_a && got_b && got_c)) begin
                @(negedge clk);
                cycle++;
            end
        end
        checkOutput({tag, "_data_a"}, dat_a, v.exp_a);
        checkOutput({tag, "_data_b"}, dat_b, v.exp_b);
        checkOutput({tag, "_data_c"}, dat_c, v.exp_c);
        checkOutput({tag, "_lat_a"}, 256'(lat_a), 256'(v.lat_a));
        checkOutput({tag, "_lat_b"}, 256'(lat_b), 256'(v.lat_b));
        checkOutput({tag, "_lat_c"}, 256'(lat_c), 256'(v.lat_c));
        checkOutput({tag, "_ready_while_busy"}, 256'({busy_c, busy_b, busy_a}), 256'(3'b000));
`ifdef IMAP_PP_BUF_STAT_EN
        exp_stall_c += v.lat_c - 2;
`endif
    endtask

    // Fill page 1 with a few tagged words covering the lanes of a base-0 read
    task automatic fillPage1();
        int addrs [10] = '{0, 1, 2, 3, 4096, 6272, 8192, 12288, 12544, 18816};
        int not_ready;
        not_ready = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!(wr_ready_a && wr_ready_b && wr_ready_c)) not_ready++;
            wr_valid = 1'b1;
            wr_addr  = 32'(addrs[i]);
            wr_data  = 64'h1_0000_0000 | 64'(addrs[i]);
            wr_last  = (i == 9);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        checkOutput("fill1_not_ready", 256'(not_ready), 256'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int fill_stall;
        int seen;
        int n;
        rd_vec_t pv;

        checks   = 0;
        failures = 0;
`ifdef IMAP_PP_BUF_STAT_EN
        exp_stall_c = 0;
`endif
        vecs[0] = '{32'd5,
                    mk4(64'd5, 64'd6277, 64'd12549, 64'd18821),
                    mk4(64'd5, 64'd4101, 64'd8197, 64'd12293),
                    mk4(64'd5, 64'd6, 64'd7, 64'd8), 2, 2, 5};
        vecs[1] = '{32'd32767,
                    mk4(64'd32767, 64'd6271, 64'd12543, 64'd18815),
                    mk4(64'd32767, 64'd4095, 64'd8191, 64'd12287),
                    mk4(64'd32767, 64'd0, 64'd1, 64'd2), 2, 2, 4};
        vecs[2] = '{32'd4094,
                    mk4(64'd4094, 64'd10366, 64'd16638, 64'd22910),
                    mk4(64'd4094, 64'd8190, 64'd12286, 64'd16382),
                    mk4(64'd4094, 64'd4095, 64'd4096, 64'd4097), 2, 2, 3};
        vecs[3] = '{32'd100000,
                    mk4(64'd1696, 64'd7968, 64'd14240, 64'd20512),
                    mk4(64'd1696, 64'd5792, 64'd9888, 64'd13984),
                    mk4(64'd1696, 64'd1697, 64'd1698, 64'd1699), 2, 2, 5};

        rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_last = 1'b0;
        rd_req_valid = 1'b0; rd_addr = '0; rd_release = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkResetState("reset");

        // Request with both pages empty must never be accepted
        rd_addr = 32'd5;
        rd_req_valid = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rd_rsp_valid_a || rd_rsp_valid_b || rd_rsp_valid_c ||
                rd_req_ready_a || rd_req_ready_b || rd_req_ready_c) seen++;
        end
        rd_req_valid = 1'b0;
        checkOutput("empty_req_no_accept", 256'(seen), 256'd0);

        // Fill page 0 with data = address
        fill_stall = 0;
        for (int i = 0; i < 32768; i++) begin
            @(negedge clk);
            if (!(wr_ready_a && wr_ready_b && wr_ready_c)) fill_stall++;
            if (i == 16384) begin
                checkOutput("mid_fill_page_full", 256'(page_full_a), 256'(2'b00));
                checkOutput("mid_fill_req_ready", 256'(rd_req_ready_a), 256'd0);
            end
            wr_valid = 1'b1;
            wr_addr  = 32'(i);
            wr_data  = 64'(i);
            wr_last  = (i == 32767);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        checkOutput("fill0_not_ready", 256'(fill_stall), 256'd0);
        checkOutput("fill0_page_full",
                    256'({page_full_c, page_full_b, page_full_a}), 256'(6'b010101));
        checkOutput("fill0_wr_ready_page1", 256'(wr_ready_a), 256'd1);

        for (int v = 0; v < 4; v++) begin
            applyStimulus(vecs[v], $sformatf("vec%0d", v));
        end
`ifdef IMAP_PP_BUF_STAT_EN
        checkOutput("stall_after_table",
                    {160'd0, stall_cnt_c, stall_cnt_b, stall_cnt_a},
                    {160'd0, 32'(exp_stall_c), 32'd0, 32'd0});
`endif

        // Fill page 1 while reading page 0
        fork
            applyStimulus(vecs[0], "overlap");
            fillPage1();
        join
        checkOutput("both_full",
                    256'({page_full_c, page_full_b, page_full_a}), 256'(6'b111111));

        // Third fill attempt is refused while both pages are full
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (wr_ready_a || wr_ready_b || wr_ready_c) seen++;
            wr_valid = 1'b1;
            wr_addr  = 32'd0;
            wr_data  = 64'hDEAD;
        end
        @(negedge clk);
        if (wr_ready_a || wr_ready_b || wr_ready_c) seen++;
        wr_valid = 1'b0;
        checkOutput("third_fill_blocked", 256'(seen), 256'd0);
        checkOutput("third_fill_page_full", 256'(page_full_a), 256'(2'b11));

        // Release during an in-flight read: read finishes on page 0, then page 0 empties
        @(negedge clk);
        rd_addr = 32'd5;
        rd_req_valid = 1'b1;
        @(negedge clk);
        rd_req_valid = 1'b0;
        rd_release = 1'b1;
        @(negedge clk);
        rd_release = 1'b0;
        checkOutput("rel_rsp_a", 256'(rd_rsp_valid_a), 256'd1);
        checkOutput("rel_data_a", rd_data_a, vecs[0].exp_a);
        checkOutput("rel_deferred_c", 256'(page_full_c), 256'(2'b11));
        n = 2;
        while (!rd_rsp_valid_c && n < 12) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rel_lat_c", 256'(n), 256'd5);
        checkOutput("rel_data_c", rd_data_c, vecs[0].exp_c);
`ifdef IMAP_PP_BUF_STAT_EN
        exp_stall_c += 3;
`endif
        @(negedge clk);
        checkOutput("rel_page_full",
                    256'({page_full_c, page_full_b, page_full_a}), 256'(6'b101010));
        checkOutput("rel_wr_ready", 256'({wr_ready_c, wr_ready_b, wr_ready_a}), 256'(3'b111));

        // Reads now come from page 1
        pv = '{32'd0,
               mk4(64'h1_0000_0000, 64'h1_0000_1880, 64'h1_0000_3100, 64'h1_0000_4980),
               mk4(64'h1_0000_0000, 64'h1_0000_1000, 64'h1_0000_2000, 64'h1_0000_3000),
               mk4(64'h1_0000_0000, 64'h1_0000_0001, 64'h1_0000_0002, 64'h1_0000_0003),
               2, 2, 5};
        applyStimulus(pv, "page1");
`ifdef IMAP_PP_BUF_STAT_EN
        checkOutput("stall_after_page1",
                    {160'd0, stall_cnt_c, stall_cnt_b, stall_cnt_a},
                    {160'd0, 32'(exp_stall_c), 32'd0, 32'd0});
`endif

        // Reset in the middle of a read discards it
        @(negedge clk);
        rd_addr = 32'd5;
        rd_req_valid = 1'b1;
        @(negedge clk);
        rd_req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkResetState("midread_reset");
        rd_req_valid = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (rd_rsp_valid_a || rd_rsp_valid_b || rd_rsp_valid_c ||
                rd_req_ready_a || rd_req_ready_b || rd_req_ready_c) seen++;
        end
        rd_req_valid = 1'b0;
        checkOutput("post_reset_no_rsp", 256'(seen), 256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
